// File: rtl/io_bus_arbiter.sv
// Two-master round-robin arbiter onto a single registered req/ack IO slave port.
// Optional wait-cycle abort is enabled by defining ARB_TIMEOUT_EN.
module io_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int CTRL_W  = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [CTRL_W-1:0] m0_ctrl,
    input  logic [DATA_W-1:0] m0_wd,
    input  logic              m0_we,
    output logic [DATA_W-1:0] m0_rd,
    output logic              m0_ack,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [CTRL_W-1:0] m1_ctrl,
    input  logic [DATA_W-1:0] m1_wd,
    input  logic              m1_we,
    output logic [DATA_W-1:0] m1_rd,
    output logic              m1_ack,
    output logic              s_req,
    output logic [ADDR_W-1:0] s_addr,
    output logic [CTRL_W-1:0] s_ctrl,
    output logic [DATA_W-1:0] s_wd,
    output logic              s_we,
    input  logic [DATA_W-1:0] s_rd,
    input  logic              s_ack,
    output logic              arb_err
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              s_req_q, s_req_d;
    logic [ADDR_W-1:0] s_addr_q, s_addr_d;
    logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
    logic [DATA_W-1:0] s_wd_q, s_wd_d;
    logic              s_we_q, s_we_d;
    logic [DATA_W-1:0] m0_rd_q, m0_rd_d;
    logic [DATA_W-1:0] m1_rd_q, m1_rd_d;
    logic              m0_ack_q, m0_ack_d;
    logic              m1_ack_q, m1_ack_d;
    logic              win;
    logic              done;
    logic              abort;
    logic [DATA_W-1:0] cap;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             tmo_hit;
    assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT));
    assign arb_err = err_q;
`else
    logic tmo_hit;
    assign tmo_hit = 1'b0;
    assign arb_err = 1'b0;
`endif

    // s_ack wins over a timeout landing on the same cycle
    assign done  = (state_q == BUSY) && s_ack;
    assign abort = (state_q == BUSY) && !s_ack && tmo_hit;
    assign cap   = s_ack ? s_rd : DATA_W'(32'hDEADBEEF);

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        s_req_d  = s_req_q;
        s_addr_d = s_addr_q;
        s_ctrl_d = s_ctrl_q;
        s_wd_d   = s_wd_q;
        s_we_d   = s_we_q;
        m0_rd_d  = m0_rd_q;
        m1_rd_d  = m1_rd_q;
        m0_ack_d = 1'b0;
        m1_ack_d = 1'b0;
        win      = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    win = (m0_req && m1_req) ? ~last_q : m1_req;
                    state_d  = BUSY;
                    owner_d  = win;
                    last_d   = win;
                    s_req_d  = 1'b1;
                    s_addr_d = win ? m1_addr : m0_addr;
                    s_ctrl_d = win ? m1_ctrl : m0_ctrl;
                    s_wd_d   = win ? m1_wd   : m0_wd;
                    s_we_d   = win ? m1_we   : m0_we;
`ifdef ARB_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end
            end
            BUSY: begin
                if (done || abort) begin
                    state_d = RESP;
                    s_req_d = 1'b0;
                    if (owner_q) begin
                        m1_rd_d  = cap;
                        m1_ack_d = 1'b1;
                    end else begin
                        m0_rd_d  = cap;
                        m0_ack_d = 1'b1;
                    end
`ifdef ARB_TIMEOUT_EN
                    err_d = abort;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            s_req_q  <= 1'b0;
            s_addr_q <= '0;
            s_ctrl_q <= '0;
            s_wd_q   <= '0;
            s_we_q   <= 1'b0;
            m0_rd_q  <= '0;
            m1_rd_q  <= '0;
            m0_ack_q <= 1'b0;
            m1_ack_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            s_req_q  <= s_req_d;
            s_addr_q <= s_addr_d;
            s_ctrl_q <= s_ctrl_d;
            s_wd_q   <= s_wd_d;
            s_we_q   <= s_we_d;
            m0_rd_q  <= m0_rd_d;
            m1_rd_q  <= m1_rd_d;
            m0_ack_q <= m0_ack_d;
            m1_ack_q <= m1_ack_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    assign s_req  = s_req_q;
    assign s_addr = s_addr_q;
    assign s_ctrl = s_ctrl_q;
    assign s_wd   = s_wd_q;
    assign s_we   = s_we_q;
    assign m0_rd  = m0_rd_q;
    assign m1_rd  = m1_rd_q;
    assign m0_ack = m0_ack_q;
    assign m1_ack = m1_ack_q;

endmodule
